// File: rtl/bsg_sipo_pkg.sv
// bsg_sipo shared types.
// Receive-side deserializer state encoding.
package bsg_sipo_pkg;

  typedef enum logic [0:0] {
    eRX = 1'b0,
    eTX = 1'b1
  } bsg_sipo_state_e;

endpackage

// File: rtl/bsg_sipo.sv
// bsg_sipo: bit-serial to parallel deserializer.
// LSB-first beats in, one width_p word out.
module bsg_sipo
  import bsg_sipo_pkg::*;
#(
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               valid_i,
  output logic               yumi_o,
  input  logic               data_i,
  output logic               valid_o,
  input  logic               yumi_i,
  output logic [width_p-1:0] data_o
);

  localparam int CtrW = (width_p < 2) ? 1 : $clog2(width_p);
  localparam logic [CtrW-1:0] LastIdx = CtrW'(width_p - 1);

  if (width_p < 2) begin : g_width_chk
    $error("bsg_sipo: width_p must be >= 2");
  end

  bsg_sipo_state_e    state_q, state_d;
  logic [CtrW-1:0]    ctr_q, ctr_d;
  logic [width_p-1:0] data_q, data_d;

  logic rx_beat;
  logic handoff;

  // Beat acceptance: demanding serial side, gated off while in reset.
  always_comb begin
    rx_beat = 1'b0;
    handoff = 1'b0;
    unique case (state_q)
      eRX: rx_beat = valid_i;
      eTX: handoff = valid_i & yumi_i;
      default: ;
    endcase
  end

  assign yumi_o  = reset_n_i & (rx_beat | handoff);
  assign valid_o = (state_q == eTX);
  assign data_o  = data_q;

  // Next-state: counter, per-bit write enables, and the word handoff.
  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    data_d  = data_q;
    unique case (state_q)
      eRX: begin
        if (rx_beat) begin
          for (int k = 0; k < width_p; k++) begin
            if (ctr_q == CtrW'(k)) data_d[k] = data_i;
          end
          if (ctr_q == LastIdx) begin
            state_d = eTX;
            ctr_d   = '0;
          end else begin
            ctr_d = ctr_q + CtrW'(1);
          end
        end
      end
      eTX: begin
        if (yumi_i) begin
          state_d = eRX;
          if (valid_i) begin
            data_d[0] = data_i;
            ctr_d     = CtrW'(1);
          end else begin
            ctr_d = '0;
          end
        end
      end
      default: begin
        state_d = eRX;
        ctr_d   = '0;
      end
    endcase
  end

  // State, counter and word registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= eRX;
      ctr_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      data_q  <= data_d;
    end
  end

  a_yumi_legal: assert property (
    @(posedge clk_i) disable iff (!reset_n_i)
    yumi_i |-> valid_o
  ) else $error("bsg_sipo: yumi_i while valid_o low");

  a_take_valid: assert property (
    @(posedge clk_i) disable iff (!reset_n_i)
    yumi_o |-> valid_i
  ) else $error("bsg_sipo: yumi_o without valid_i");

  a_hold_word: assert property (
    @(posedge clk_i) disable iff (!reset_n_i)
    (valid_o && !yumi_i) |=> $stable(data_o)
  ) else $error("bsg_sipo: data_o changed while held");

endmodule
